// File: rtl/alu_acc_stepper.sv
// Board-level ALU demo: synchronised active-low switches and buttons drive a
// WIDTH-bit accumulator with registered zero/carry flags and a step counter.

module alu_acc_stepper_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic pulse_o
);
   localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        level_q, level_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pulse_q, pulse_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (level_i != level_q) begin
         if (cnt_q == LAST) begin
            level_d = level_i;
            pulse_d = level_i;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;
endmodule

module alu_acc_stepper #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           opcode_n,
   input  logic [WIDTH-1:0]     a_n,
   input  logic [WIDTH-1:0]     b_n,
   input  logic                 step_n,
   input  logic                 load_n,
   output logic [WIDTH-1:0]     acc,
   output logic                 zf,
   output logic                 cf,
   output logic [WIDTH-1:0]     a_led,
   output logic [WIDTH-1:0]     b_led,
   output logic [CNT_WIDTH-1:0] step_cnt
);
   localparam int SW = 4 + 2 * WIDTH + 2;

   logic [SW-1:0]        sync1_q, sync2_q;
   logic [3:0]           op_s;
   logic [WIDTH-1:0]     a_s, b_s;
   logic                 step_s, load_s, step_p, load_p;

   logic [WIDTH-1:0]     acc_q, acc_d;
   logic                 zf_q, zf_d, cf_q, cf_d;
   logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;

   logic [WIDTH:0]       ext_acc, ext_b, ext_cf, wide;
   logic [WIDTH-1:0]     res;
   logic                 res_c;

   // Reset loads the released/off level so nothing looks pressed afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= {opcode_n, a_n, b_n, step_n, load_n};
         sync2_q <= sync1_q;
      end
   end

   assign {op_s, a_s, b_s, step_s, load_s} = ~sync2_q;

   alu_acc_stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk(clk), .rst(rst), .level_i(step_s), .pulse_o(step_p)
   );
   alu_acc_stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .clk(clk), .rst(rst), .level_i(load_s), .pulse_o(load_p)
   );

   assign ext_acc = {1'b0, acc_q};
   assign ext_b   = {1'b0, b_s};
   assign ext_cf  = {{WIDTH{1'b0}}, cf_q};

   // One extra bit on arithmetic ops: the top bit is the carry or borrow.
   always_comb begin
      wide  = '0;
      res   = acc_q;
      res_c = cf_q;
      case (op_s)
         4'd0:  begin wide = ext_acc + ext_b;          res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd1:  begin wide = ext_acc + ext_b + ext_cf; res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd2:  begin wide = ext_acc - ext_b;          res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd3:  begin wide = ext_acc - ext_b - ext_cf; res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd4:  begin res = acc_q & b_s; res_c = 1'b0; end
         4'd5:  begin res = acc_q | b_s; res_c = 1'b0; end
         4'd6:  begin res = acc_q ^ b_s; res_c = 1'b0; end
         4'd7:  begin res = ~acc_q;      res_c = 1'b0; end
         4'd8:  begin res = acc_q << 1;  res_c = acc_q[WIDTH-1]; end
         4'd9:  begin res = acc_q >> 1;  res_c = acc_q[0]; end
         4'd10: begin res = {acc_q[WIDTH-2:0], cf_q}; res_c = acc_q[WIDTH-1]; end
         4'd11: begin res = {cf_q, acc_q[WIDTH-1:1]}; res_c = acc_q[0]; end
         4'd12: begin wide = ext_acc + 1'b1; res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd13: begin wide = ext_acc - 1'b1; res = wide[WIDTH-1:0]; res_c = wide[WIDTH]; end
         4'd14: begin res = b_s; res_c = 1'b0; end
         default: begin res = acc_q; res_c = cf_q; end
      endcase
   end

   // LOAD takes priority; a STEP arriving in the same cycle is dropped.
   always_comb begin
      acc_d      = acc_q;
      zf_d       = zf_q;
      cf_d       = cf_q;
      step_cnt_d = step_cnt_q;
      if (load_p) begin
         acc_d = a_s;
         zf_d  = (a_s == '0);
         cf_d  = 1'b0;
      end else if (step_p && (op_s != 4'd15)) begin
         acc_d      = res;
         zf_d       = (res == '0);
         cf_d       = res_c;
         step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         zf_q       <= 1'b0;
         cf_q       <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         acc_q      <= acc_d;
         zf_q       <= zf_d;
         cf_q       <= cf_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign acc      = acc_q;
   assign zf       = zf_q;
   assign cf       = cf_q;
   assign step_cnt = step_cnt_q;
   assign a_led    = a_s;
   assign b_led    = b_s;
endmodule

// File: tb/tb_alu_acc_stepper.sv
// Directed bench for alu_acc_stepper: a 4-bit instance with a vector table
// plus hand sequences, and an 8-bit instance for the rotate-through-carry case.

module tb_alu_acc_stepper;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode_n = 4'hF;

   logic [3:0] a4_n = 4'hF, b4_n = 4'hF;
   logic       step4_n = 1'b1, load4_n = 1'b1;
   logic [3:0] acc4, a_led4, b_led4;
   logic       zf4, cf4;
   logic [7:0] cnt4;

   logic [7:0] a8_n = 8'hFF, b8_n = 8'hFF;
   logic       step8_n = 1'b1, load8_n = 1'b1;
   logic [7:0] acc8, a_led8, b_led8;
   logic       zf8, cf8;
   logic [7:0] cnt8;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit         is_load;
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] e_acc;
      bit         e_zf;
      bit         e_cf;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[21];

   always #5 clk = ~clk;

   alu_acc_stepper #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut4 (
      .clk(clk), .rst(rst), .opcode_n(opcode_n), .a_n(a4_n), .b_n(b4_n),
      .step_n(step4_n), .load_n(load4_n), .acc(acc4), .zf(zf4), .cf(cf4),
      .a_led(a_led4), .b_led(b_led4), .step_cnt(cnt4)
   );

   alu_acc_stepper #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .opcode_n(opcode_n), .a_n(a8_n), .b_n(b8_n),
      .step_n(step8_n), .load_n(load8_n), .acc(acc8), .zf(zf8), .cf(cf8),
      .a_led(a_led8), .b_led(b_led8), .step_cnt(cnt8)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic press(input bit w8, input bit s, input bit l);
      @(posedge clk); #1;
      if (w8) begin
         step8_n = ~s; load8_n = ~l;
      end else begin
         step4_n = ~s; load4_n = ~l;
      end
      repeat (12) @(posedge clk);
      #1;
      step4_n = 1'b1; load4_n = 1'b1; step8_n = 1'b1; load8_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check4(input string name, input logic [3:0] e_acc, input bit e_zf,
                         input bit e_cf, input logic [7:0] e_cnt);
      check({name, ".acc"}, acc4, e_acc);
      check({name, ".zf"},  zf4,  e_zf);
      check({name, ".cf"},  cf4,  e_cf);
      check({name, ".cnt"}, cnt4, e_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //             load  op     a      b      acc    zf    cf    cnt
      vecs[0]  = '{1'b0, 4'd0,  4'd0,  4'd8,  4'd1,  1'b0, 1'b1, 8'd1};
      vecs[1]  = '{1'b0, 4'd1,  4'd0,  4'd0,  4'd2,  1'b0, 1'b0, 8'd2};
      vecs[2]  = '{1'b1, 4'd0,  4'd3,  4'd0,  4'd3,  1'b0, 1'b0, 8'd2};
      vecs[3]  = '{1'b0, 4'd2,  4'd0,  4'd5,  4'd14, 1'b0, 1'b1, 8'd3};
      vecs[4]  = '{1'b0, 4'd3,  4'd0,  4'd1,  4'd12, 1'b0, 1'b0, 8'd4};
      vecs[5]  = '{1'b0, 4'd4,  4'd0,  4'd10, 4'd8,  1'b0, 1'b0, 8'd5};
      vecs[6]  = '{1'b0, 4'd5,  4'd0,  4'd3,  4'd11, 1'b0, 1'b0, 8'd6};
      vecs[7]  = '{1'b0, 4'd6,  4'd0,  4'd11, 4'd0,  1'b1, 1'b0, 8'd7};
      vecs[8]  = '{1'b0, 4'd7,  4'd0,  4'd0,  4'd15, 1'b0, 1'b0, 8'd8};
      vecs[9]  = '{1'b0, 4'd8,  4'd0,  4'd0,  4'd14, 1'b0, 1'b1, 8'd9};
      vecs[10] = '{1'b0, 4'd10, 4'd0,  4'd0,  4'd13, 1'b0, 1'b1, 8'd10};
      vecs[11] = '{1'b0, 4'd11, 4'd0,  4'd0,  4'd14, 1'b0, 1'b1, 8'd11};
      vecs[12] = '{1'b0, 4'd9,  4'd0,  4'd0,  4'd7,  1'b0, 1'b0, 8'd12};
      vecs[13] = '{1'b0, 4'd12, 4'd0,  4'd0,  4'd8,  1'b0, 1'b0, 8'd13};
      vecs[14] = '{1'b1, 4'd0,  4'd15, 4'd0,  4'd15, 1'b0, 1'b0, 8'd13};
      vecs[15] = '{1'b0, 4'd12, 4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 8'd14};
      vecs[16] = '{1'b1, 4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 8'd14};
      vecs[17] = '{1'b0, 4'd13, 4'd0,  4'd0,  4'd15, 1'b0, 1'b1, 8'd15};
      vecs[18] = '{1'b0, 4'd15, 4'd0,  4'd9,  4'd15, 1'b0, 1'b1, 8'd15};
      vecs[19] = '{1'b0, 4'd14, 4'd0,  4'd6,  4'd6,  1'b0, 1'b0, 8'd16};
      vecs[20] = '{1'b0, 4'd13, 4'd0,  4'd0,  4'd5,  1'b0, 1'b0, 8'd17};

      // Reset and idle
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check4("reset", 4'd0, 1'b0, 1'b0, 8'd0);
      check("reset.a_led", a_led4, 4'd0);
      check("reset.b_led", b_led4, 4'd0);
      repeat (100) @(negedge clk);
      check4("idle", 4'd0, 1'b0, 1'b0, 8'd0);
      check("idle.a_led", a_led4, 4'd0);

      // LOAD latency: acc changes on exactly the 7th edge after the pin goes low
      @(posedge clk); #1;
      a4_n = ~4'd9; load4_n = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         if (e == 6) check("lat.edge6.acc", acc4, 4'd0);
      end
      check("lat.edge7.acc", acc4, 4'd9);
      check("lat.edge7.zf", zf4, 1'b0);
      check("lat.edge7.cf", cf4, 1'b0);
      check("lat.a_led", a_led4, 4'd9);
      repeat (5) @(posedge clk);
      #1 load4_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check4("lat.held", 4'd9, 1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 21; i++) begin
         opcode_n = ~vecs[i].op;
         a4_n     = ~vecs[i].a;
         b4_n     = ~vecs[i].b;
         press(1'b0, ~vecs[i].is_load, vecs[i].is_load);
         check4($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_zf, vecs[i].e_cf, vecs[i].e_cnt);
         check($sformatf("vec%0d.b_led", i), b_led4, vecs[i].b);
      end

      // Bounce: short low bursts never qualify, a long hold executes once
      opcode_n = ~4'd0; b4_n = ~4'd1;
      for (int r = 0; r < 5; r++) begin
         @(posedge clk); #1 step4_n = 1'b0;
         repeat (3) @(posedge clk);
         #1 step4_n = 1'b1;
      end
      repeat (12) @(posedge clk);
      @(negedge clk);
      check4("bounce.glitch", 4'd5, 1'b0, 1'b0, 8'd17);
      @(posedge clk); #1 step4_n = 1'b0;
      repeat (40) @(posedge clk);
      #1 step4_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check4("bounce.hold", 4'd6, 1'b0, 1'b0, 8'd18);

      // Collision: LOAD wins over STEP in the same cycle
      opcode_n = ~4'd0; a4_n = ~4'd5; b4_n = ~4'd1;
      press(1'b0, 1'b1, 1'b1);
      check4("collide", 4'd5, 1'b0, 1'b0, 8'd18);

      // NOP changes nothing
      opcode_n = ~4'd15;
      press(1'b0, 1'b1, 1'b0);
      check4("nop", 4'd5, 1'b0, 1'b0, 8'd18);

      // Reset in the middle of a debounce discards the press
      opcode_n = ~4'd12;
      @(posedge clk); #1 step4_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check4("rstmid.reset", 4'd0, 1'b0, 1'b0, 8'd0);
      check("rstmid.a_led", a_led4, 4'd0);
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         if (e == 6) begin
            check("rstmid.edge6.acc", acc4, 4'd0);
            check("rstmid.edge6.cnt", cnt4, 8'd0);
         end
      end
      check4("rstmid.edge7", 4'd1, 1'b0, 1'b0, 8'd1);
      #1 step4_n = 1'b1;
      repeat (12) @(posedge clk);

      // WIDTH=8: reach acc=0x80 with cf=1, then rotate left through carry
      a8_n = ~8'hC0;
      press(1'b1, 1'b0, 1'b1);
      check("w8.load.acc", acc8, 8'hC0);
      opcode_n = ~4'd8;
      press(1'b1, 1'b1, 1'b0);
      check("w8.shl.acc", acc8, 8'h80);
      check("w8.shl.cf", cf8, 1'b1);
      opcode_n = ~4'd10;
      press(1'b1, 1'b1, 1'b0);
      check("w8.rol.acc", acc8, 8'h01);
      check("w8.rol.cf", cf8, 1'b1);
      check("w8.rol.zf", zf8, 1'b0);
      check("w8.rol.cnt", cnt8, 8'd2);
      check("w8.a_led", a_led8, 8'hC0);
      check("w8.b_led", b_led8, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
